// File: rtl/nv_mem_ctrl.sv
// Burst controller for a synchronous NV memory with a 1-cycle registered read.
// Splits write/read bursts into single-word accesses and returns read beats via a 2-stage pipe.
module nv_mem_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_data_valid,
    output logic                  wr_data_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic                  mem_w,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CNT_W = LEN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Read pipe: stage 1 tracks the issued address, stage 2 the memory output.
    logic issue_v_q, issue_v_d, issue_last_q, issue_last_d;
    logic rd_v2_q, rd_v2_d, rd_last2_q, rd_last2_d;

    logic                  req_ready_d, wr_data_ready_d;
    logic                  rd_data_valid_d, rd_last_d, done_d, mem_w_d;
    logic [DATA_WIDTH-1:0] rd_data_d, mem_wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;

    logic accept_c, beat_wr_c, last_beat_c, rd_final_c;

    assign accept_c    = (state_q == IDLE) && req_valid && req_ready;
    assign beat_wr_c   = (state_q == WRITE) && wr_data_valid && wr_data_ready;
    assign last_beat_c = (cnt_q == {1'b0, len_q});
    assign rd_final_c  = rd_v2_q && rd_last2_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_d = req_write ? WRITE : READ;
            WRITE:   if (beat_wr_c && last_beat_c) state_d = IDLE;
            READ:    if (last_beat_c) state_d = DRAIN;
            DRAIN:   if (rd_final_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the datapath and of every registered output
    always_comb begin
        addr_d          = addr_q;
        len_d           = len_q;
        cnt_d           = cnt_q;
        mem_w_d         = 1'b0;
        mem_addr_d      = mem_addr;
        mem_wdata_d     = mem_wdata;
        issue_v_d       = 1'b0;
        issue_last_d    = 1'b0;
        rd_v2_d         = issue_v_q;
        rd_last2_d      = issue_last_q;
        rd_data_valid_d = rd_v2_q;
        rd_last_d       = rd_final_c;
        rd_data_d       = rd_v2_q ? mem_rdata : rd_data;
        done_d          = rd_final_c;
        req_ready_d     = (state_d == IDLE);
        wr_data_ready_d = (state_d == WRITE);

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    addr_d = req_addr;
                    len_d  = req_len;
                    cnt_d  = '0;
                end
            end
            WRITE: begin
                if (beat_wr_c) begin
                    mem_w_d     = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wr_data;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    cnt_d       = cnt_q + CNT_W'(1);
                    done_d      = last_beat_c;
                end
            end
            READ: begin
                mem_addr_d   = addr_q;
                issue_v_d    = 1'b1;
                issue_last_d = last_beat_c;
                addr_d       = addr_q + ADDR_WIDTH'(1);
                cnt_d        = cnt_q + CNT_W'(1);
            end
            DRAIN: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            issue_v_q     <= 1'b0;
            issue_last_q  <= 1'b0;
            rd_v2_q       <= 1'b0;
            rd_last2_q    <= 1'b0;
            req_ready     <= 1'b0;
            wr_data_ready <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            rd_last       <= 1'b0;
            done          <= 1'b0;
            mem_w         <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            addr_q        <= addr_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            issue_v_q     <= issue_v_d;
            issue_last_q  <= issue_last_d;
            rd_v2_q       <= rd_v2_d;
            rd_last2_q    <= rd_last2_d;
            req_ready     <= req_ready_d;
            wr_data_ready <= wr_data_ready_d;
            rd_data_valid <= rd_data_valid_d;
            rd_data       <= rd_data_d;
            rd_last       <= rd_last_d;
            done          <= done_d;
            mem_w         <= mem_w_d;
            mem_addr      <= mem_addr_d;
            mem_wdata     <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_nv_mem_ctrl.sv
// Directed bench for nv_mem_ctrl: behavioural NV memory, write/read event logs, immediate assertions.
module tb_nv_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [3:0]  req_len;
    logic        wr_data_valid, wr_data_ready;
    logic [31:0] wr_data;
    logic        rd_data_valid, rd_last, done;
    logic [31:0] rd_data;
    logic        mem_w;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    nv_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done),
        .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous NV memory: registered read, write on mem_w.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_w) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct { logic [7:0] addr; logic [31:0] data; logic done; } wr_ev_t;
    typedef struct { logic [31:0] data; logic last; logic done; int cyc; } rd_ev_t;
    wr_ev_t wlog[$];
    rd_ev_t rlog[$];

    int cyc = 0;
    int n_acc = 0;
    int acc_cyc;
    int passed = 0, failed = 0, total = 0;
    logic [31:0] wd [16];
    int          gap [16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_w) wlog.push_back('{addr: mem_addr, data: mem_wdata, done: done});
        if (rd_data_valid) rlog.push_back('{data: rd_data, last: rd_last, done: done, cyc: cyc});
        if (req_valid && req_ready) n_acc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic w, input logic [7:0] a, input logic [3:0] l);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
        for (int i = 0; i < 40 && !req_ready; i++) tick();
        chk("req_ready_before_accept", 64'(req_ready), 64'd1);
        tick();
        acc_cyc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] a, input logic [3:0] l);
        wlog.delete();
        do_req(1'b1, a, l);
        for (int k = 0; k <= int'(l); k++) begin
            repeat (gap[k]) tick();
            wr_data_valid = 1'b1;
            wr_data = wd[k];
            tick();
            wr_data_valid = 1'b0;
        end
        repeat (3) tick();
    endtask

    task automatic read_burst(input logic [7:0] a, input logic [3:0] l);
        rlog.delete();
        do_req(1'b0, a, l);
        repeat (int'(l) + 6) tick();
    endtask

    task automatic check_writes(input string tag, input logic [7:0] a0, input int n);
        logic [7:0] a;
        chk({tag, "_count"}, 64'(wlog.size()), 64'(n));
        for (int k = 0; k < n && k < wlog.size(); k++) begin
            a = a0 + 8'(k);
            chk({tag, "_addr"}, 64'(wlog[k].addr), 64'(a));
            chk({tag, "_data"}, 64'(wlog[k].data), 64'(wd[k]));
            chk({tag, "_done"}, 64'(wlog[k].done), 64'(k == n - 1));
        end
    endtask

    task automatic check_reads(input string tag, input int n);
        chk({tag, "_count"}, 64'(rlog.size()), 64'(n));
        for (int k = 0; k < n && k < rlog.size(); k++) begin
            chk({tag, "_data"}, 64'(rlog[k].data), 64'(wd[k]));
            chk({tag, "_last"}, 64'(rlog[k].last), 64'(k == n - 1));
            chk({tag, "_done"}, 64'(rlog[k].done), 64'(k == n - 1));
            chk({tag, "_cycle"}, 64'(rlog[k].cyc), 64'(acc_cyc + 3 + k));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 16; i++) gap[i] = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h0; req_len = 4'h0;
        wr_data_valid = 1'b0; wr_data = 32'h0;

        // Reset state
        repeat (3) tick();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_wr_data_ready", 64'(wr_data_ready), 64'd0);
        chk("rst_mem_w", 64'(mem_w), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_rd_valid", 64'(rd_data_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_rd_last", 64'(rd_last), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready_pre_edge", 64'(req_ready), 64'd0);
        tick();
        chk("rel_req_ready_first_edge", 64'(req_ready), 64'd1);

        // Single write and read-back
        wd[0] = 32'hDEADBEEF;
        write_burst(8'h10, 4'd0);
        check_writes("single_wr", 8'h10, 1);
        read_burst(8'h10, 4'd0);
        check_reads("single_rd", 1);

        // Burst with a 2-cycle wr_data_valid gap before beat 2
        for (int k = 0; k < 4; k++) wd[k] = 32'(k + 1);
        gap[2] = 2;
        write_burst(8'h20, 4'd3);
        gap[2] = 0;
        check_writes("burst_wr", 8'h20, 4);
        read_burst(8'h20, 4'd3);
        check_reads("burst_rd", 4);

        // Address wrap 0xFE -> 0x01
        for (int k = 0; k < 4; k++) wd[k] = 32'hA0 + 32'(k);
        write_burst(8'hFE, 4'd3);
        check_writes("wrap_wr", 8'hFE, 4);
        read_burst(8'hFE, 4'd3);
        check_reads("wrap_rd", 4);

        // 16-beat read, req_valid (now a write) and wr_data_valid held high throughout
        for (int k = 0; k < 16; k++) wd[k] = (k < 4) ? 32'(k + 1) : 32'h0;
        rlog.delete(); wlog.delete();
        n_acc = 0;
        do_req(1'b0, 8'h20, 4'd15);
        req_valid = 1'b1; req_write = 1'b1;
        wr_data_valid = 1'b1; wr_data = 32'h5555;
        for (int i = 0; i < 30 && !done; i++) tick();
        req_valid = 1'b0; wr_data_valid = 1'b0;
        chk("max_done_seen", 64'(done), 64'd1);
        chk("max_single_accept", 64'(n_acc), 64'd1);
        chk("max_no_writes", 64'(wlog.size()), 64'd0);
        chk("max_ready_after_done", 64'(req_ready), 64'd1);
        repeat (3) tick();
        check_reads("max_rd", 16);

        // wr_data_valid in IDLE is ignored
        wlog.delete();
        wr_data_valid = 1'b1; wr_data = 32'hBAD;
        repeat (5) tick();
        wr_data_valid = 1'b0;
        chk("idle_wrvalid_no_write", 64'(wlog.size()), 64'd0);
        chk("idle_wrvalid_ready", 64'(wr_data_ready), 64'd0);

        // Reset in the middle of an 8-beat write, right after beat 2 is taken
        wlog.delete();
        for (int k = 0; k < 8; k++) wd[k] = 32'h100 + 32'(k);
        do_req(1'b1, 8'h40, 4'd7);
        for (int k = 0; k < 3; k++) begin
            wr_data_valid = 1'b1; wr_data = wd[k];
            tick();
        end
        chk("midrst_mem_w_before", 64'(mem_w), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_w_drop", 64'(mem_w), 64'd0);
        chk("midrst_wr_ready_drop", 64'(wr_data_ready), 64'd0);
        repeat (3) tick();
        wr_data_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("midrst_ready_after_rel", 64'(req_ready), 64'd1);
        repeat (4) tick();
        chk("midrst_write_count", 64'(wlog.size()), 64'd2);
        read_burst(8'h40, 4'd0);
        check_reads("midrst_rd", 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
